button_conditioner: RTL

//  Upstream front end for the shift-add multiplier datapath. Conditions the raw

---
 rtl/button_conditioner_if.sv | 40 ++++
 rtl/button_conditioner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
//
// Purpose
//   Bundles the per-button signals of the push-button front end so that the
//   key source (board pins or a bench) and the conditioner connect through one
//   port. The clock and reset stay as plain scalar ports on the conditioner.
//
// Signals (all N_BTN wide, one bit per button lane, active-low levels)
//   Key_n    raw asynchronous push-buttons; 0 = pressed
//   Btn_n    debounced level; 0 = pressed
//   Press    1-cycle strobe when Btn_n falls 1->0
//   Release  1-cycle strobe when Btn_n rises 0->1
//
// Modports
//   master   key source: drives Key_n, observes the conditioned outputs
//   slave    the conditioner: samples Key_n, drives Btn_n / Press / Release
// -----------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] Key_n;
    logic [N_BTN-1:0] Btn_n;
    logic [N_BTN-1:0] Press;
    logic [N_BTN-1:0] Release;

    modport master (
        output Key_n,
        input  Btn_n,
        input  Press,
        input  Release
    );

    modport slave (
        input  Key_n,
        output Btn_n,
        output Press,
        output Release
    );
endinterface : button_conditioner_if

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose
//   Front end for the shift-add multiplier datapath. Conditions the raw
//   active-low push-buttons (Reset, ClearA_LoadB, Run keys) before the control
//   FSM uses them. Each button is an independent lane made of:
//     - a SYNC_STAGES-deep synchronizer on the asynchronous key,
//     - a four-state debounce FSM with a stability counter,
//     - a registered debounced level (Btn_n),
//     - registered single-cycle Press / Release strobes.
//   Lanes share no state, so several lanes may strobe in the same cycle.
//
// Parameters
//   N_BTN        number of independent button lanes
//   SYNC_STAGES  flops per synchronizer chain (must be >= 2)
//   DB_CYCLES    consecutive stable synchronized samples needed to accept a
//                change (must be >= 1)
//
// Ports
//   Clk      in   system clock; all state updates on posedge
//   Reset    in   synchronous, active-low reset
//   bus      slave modport of button_conditioner_if
//              Key_n   in   raw keys, 0 = pressed
//              Btn_n   out  debounced level, 0 = pressed
//              Press   out  1-cycle strobe on Btn_n 1->0
//              Release out  1-cycle strobe on Btn_n 0->1
//
// Timing
//   A key edge that is settled before posedge k is first captured at edge k.
//   It reaches the FSM SYNC_STAGES edges later and must then be seen on
//   DB_CYCLES consecutive edges, so Btn_n changes after posedge
//   k + SYNC_STAGES + DB_CYCLES - 1. The matching strobe is high in exactly
//   the first cycle of the new Btn_n value. Any opposite sample inside the
//   acceptance window sends the lane back to its stable state, so acceptance
//   restarts from zero.
//
// Reset behaviour
//   Reset loads the synchronizers with 1 (released), so a key held through
//   reset is seen as released; the lane re-debounces it afterwards and issues
//   a fresh Press. No strobe of any kind is produced by reset itself, and no
//   Release is produced for a press that reset discarded.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int N_BTN       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 50000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    button_conditioner_if.slave   bus
);

    // Counter must hold values up to DB_CYCLES-1; the extra headroom of
    // $clog2(DB_CYCLES+1) keeps the width at least one bit for DB_CYCLES==1.
    localparam int CW = $clog2(DB_CYCLES + 1);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    // With a one-sample window there is nothing to wait for: the first
    // differing synchronized sample is accepted immediately.
    localparam bit DIRECT_ACCEPT = (DB_CYCLES == 32'sd1);

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,  // stable released, Btn_n = 1
        ST_PEND_DN = 2'd1,  // released, counting consecutive pressed samples
        ST_DN      = 2'd2,  // stable pressed, Btn_n = 0
        ST_PEND_UP = 2'd3   // pressed, counting consecutive released samples
    } lane_state_e;

    logic [N_BTN-1:0] key_n_s;
    logic [N_BTN-1:0] btn_n_s;
    logic [N_BTN-1:0] press_s;
    logic [N_BTN-1:0] release_s;

    assign key_n_s = bus.Key_n;

    for (genvar g = 0; g < N_BTN; g++) begin : g_lane

        logic [SYNC_STAGES-1:0] sync_r;
        logic                   samp_s;

        lane_state_e            state_r;
        lane_state_e            state_nx_s;
        logic [CW-1:0]          cnt_r;
        logic [CW-1:0]          cnt_nx_s;

        logic                   btn_n_r;
        logic                   btn_n_nx_s;
        logic                   press_r;
        logic                   press_nx_s;
        logic                   release_r;
        logic                   release_nx_s;

        // Synchronizer chain: shifts the raw key in at bit 0; reset fills with released.
        always_ff @(posedge Clk) begin
            if (!Reset) begin
                sync_r <= {SYNC_STAGES{1'b1}};
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], key_n_s[g]};
            end
        end

        // Only the last synchronizer stage is ever looked at downstream.
        assign samp_s = sync_r[SYNC_STAGES-1];

        // Debounce next-state, counter and output decisions for this lane.
        always_comb begin
            state_nx_s   = state_r;
            cnt_nx_s     = cnt_r;
            btn_n_nx_s   = btn_n_r;
            press_nx_s   = 1'b0;
            release_nx_s = 1'b0;

            case (state_r)
                ST_UP: begin
                    btn_n_nx_s = 1'b1;
                    if (!samp_s) begin
                        if (DIRECT_ACCEPT) begin
                            state_nx_s = ST_DN;
                            btn_n_nx_s = 1'b0;
                            press_nx_s = 1'b1;
                            cnt_nx_s   = CNT_ZERO;
                        end else begin
                            // This sample is the first of the window.
                            state_nx_s = ST_PEND_DN;
                            cnt_nx_s   = CNT_ONE;
                        end
                    end else begin
                        cnt_nx_s = CNT_ZERO;
                    end
                end

                ST_PEND_DN: begin
                    if (samp_s) begin
                        // Bounce: drop back without touching the outputs.
                        state_nx_s = ST_UP;
                        cnt_nx_s   = CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nx_s = ST_DN;
                        btn_n_nx_s = 1'b0;
                        press_nx_s = 1'b1;
                        cnt_nx_s   = CNT_ZERO;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end

                ST_DN: begin
                    btn_n_nx_s = 1'b0;
                    if (samp_s) begin
                        if (DIRECT_ACCEPT) begin
                            state_nx_s   = ST_UP;
                            btn_n_nx_s   = 1'b1;
                            release_nx_s = 1'b1;
                            cnt_nx_s     = CNT_ZERO;
                        end else begin
                            state_nx_s = ST_PEND_UP;
                            cnt_nx_s   = CNT_ONE;
                        end
                    end else begin
                        cnt_nx_s = CNT_ZERO;
                    end
                end

                ST_PEND_UP: begin
                    if (!samp_s) begin
                        state_nx_s = ST_DN;
                        cnt_nx_s   = CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nx_s   = ST_UP;
                        btn_n_nx_s   = 1'b1;
                        release_nx_s = 1'b1;
                        cnt_nx_s     = CNT_ZERO;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a quiet released lane.
                    state_nx_s = ST_UP;
                    cnt_nx_s   = CNT_ZERO;
                    btn_n_nx_s = 1'b1;
                end
            endcase
        end

        // Lane state, counter and registered outputs; reset forces a quiet released lane.
        always_ff @(posedge Clk) begin
            if (!Reset) begin
                state_r   <= ST_UP;
                cnt_r     <= CNT_ZERO;
                btn_n_r   <= 1'b1;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                state_r   <= state_nx_s;
                cnt_r     <= cnt_nx_s;
                btn_n_r   <= btn_n_nx_s;
                press_r   <= press_nx_s;
                release_r <= release_nx_s;
            end
        end

        assign btn_n_s[g]   = btn_n_r;
        assign press_s[g]   = press_r;
        assign release_s[g] = release_r;

    end : g_lane

    assign bus.Btn_n   = btn_n_s;
    assign bus.Press   = press_s;
    assign bus.Release = release_s;

endmodule : button_conditioner
